// File: rtl/alu_mc_if.sv
`timescale 1ns/1ps
// alu_mc_if: operand/result handshake bundle for the multi-cycle ALU.
// master = pipeline side issuing operations; slave = the ALU itself.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zf;
    logic             dz;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, lo, hi, zf, dz
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, lo, hi, zf, dz
    );
endinterface

// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: multi-cycle integer ALU for the MIPS EX stage.
// Single-cycle logic/arith ops, SLT/SLTU, shift-add MULTU and restoring DIVU
// producing {hi,lo}. Operands are captured on accept; results are registered
// and held in DONE until the consumer takes them.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_SLT   = 4'b1101,
        OP_NOR   = 4'b1100,
        OP_MULTU = 4'b1000,
        OP_DIVU  = 4'b1001
    } op_e;

    state_e           state;
    state_e           state_nx;

    // opnd: multiplicand (MUL) or divisor (DIV)
    // acc_hi/acc_lo: partial product (MUL) or remainder/quotient-dividend (DIV)
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic             zf_r;
    logic             dz_r;

    logic [WIDTH-1:0] sc_lo;
    logic             div_zero;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;

    assign div_zero = (bus.b == '0);
    assign last     = (cnt == CW'(WIDTH - 1));

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.lo        = lo_r;
    assign bus.hi        = hi_r;
    assign bus.zf        = zf_r;
    assign bus.dz        = dz_r;

    // Single-cycle result from the live operands, used only at accept.
    always_comb begin
        sc_lo = '0;
        case (op_e'(bus.sel))
            OP_AND:  sc_lo = bus.a & bus.b;
            OP_OR:   sc_lo = bus.a | bus.b;
            OP_ADD:  sc_lo = bus.a + bus.b;
            OP_SUB:  sc_lo = bus.a - bus.b;
            OP_SLTU: sc_lo = WIDTH'(bus.a < bus.b);
            OP_SLT:  sc_lo = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_NOR:  sc_lo = ~(bus.a | bus.b);
            default: sc_lo = '0;
        endcase
    end

    // One shift-add multiply step: add multiplicand if LSB set, shift {hi,lo} right.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        {mul_hi_nx, mul_lo_nx} = {mul_sum, acc_lo[WIDTH-1:1]};
    end

    // One restoring-division step: shift next dividend bit into remainder, try subtract.
    // The remainder stays below the divisor, so bit WIDTH of the difference is its sign.
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            div_hi_nx = div_diff[WIDTH-1:0];
            div_lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_nx = div_shift[WIDTH-1:0];
            div_lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: route accepted ops to MUL, DIV or straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (op_e'(bus.sel) == OP_MULTU) begin
                        state_nx = S_MUL;
                    end else if (op_e'(bus.sel) == OP_DIVU && !div_zero) begin
                        state_nx = S_DIV;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_MUL:   if (last) state_nx = S_DONE;
            S_DIV:   if (last) state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in MUL/DIV, load result registers on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            lo_r   <= '0;
            hi_r   <= '0;
            zf_r   <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        cnt <= '0;
                        if (op_e'(bus.sel) == OP_MULTU) begin
                            opnd   <= bus.a;
                            acc_hi <= '0;
                            acc_lo <= bus.b;
                        end else if (op_e'(bus.sel) == OP_DIVU) begin
                            if (div_zero) begin
                                lo_r <= '1;
                                hi_r <= bus.a;
                                zf_r <= 1'b0;
                                dz_r <= 1'b1;
                            end else begin
                                opnd   <= bus.b;
                                acc_hi <= '0;
                                acc_lo <= bus.a;
                            end
                        end else begin
                            lo_r <= sc_lo;
                            hi_r <= '0;
                            zf_r <= (sc_lo == '0);
                            dz_r <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        lo_r <= mul_lo_nx;
                        hi_r <= mul_hi_nx;
                        zf_r <= (mul_lo_nx == '0);
                        dz_r <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_hi <= div_hi_nx;
                    acc_lo <= div_lo_nx;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        lo_r <= div_lo_nx;
                        hi_r <= div_hi_nx;
                        zf_r <= (div_lo_nx == '0);
                        dz_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// tb_alu_mc: directed, self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".idle"}, bus.in_ready, 1);
    endtask

    task automatic run(input string tag, input logic [3:0] s,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edz, input int elat);
        int   cyc;
        logic busy;
        wait_idle(tag);
        bus.sel      = s;
        bus.a        = va;
        bus.b        = vb;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.sel      = 4'($urandom);
        cyc  = 1;
        busy = bus.in_ready;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.in_ready) busy = 1'b1;
        end
        check({tag, ".lat"}, cyc, elat);
        check({tag, ".lo"}, bus.lo, elo);
        check({tag, ".hi"}, bus.hi, ehi);
        check({tag, ".zf"}, bus.zf, (elo == 32'h0));
        check({tag, ".dz"}, bus.dz, edz);
        check({tag, ".busy_ready"}, busy, 0);
        @(posedge clk); #1;
        check({tag, ".ov_drop"}, bus.out_valid, 0);
        check({tag, ".ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        int   saw;
        tests = 0;
        fails = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst.lo", bus.lo, 0);
        check("rst.hi", bus.hi, 0);
        check("rst.zf", bus.zf, 0);
        check("rst.dz", bus.dz, 0);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        run("add",    4'b0010, 32'd7,        32'd5,        32'd12,       32'd0, 1'b0, 1);
        run("sub",    4'b0110, 32'd5,        32'd5,        32'd0,        32'd0, 1'b0, 1);
        run("slt",    4'b1101, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 1'b0, 1);
        run("sltu",   4'b0111, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b0, 1);
        run("inval",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'd0,        32'd0, 1'b0, 1);
        run("and",    4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'd0, 1'b0, 1);
        run("or",     4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'd0, 1'b0, 1);
        run("nor",    4'b1100, 32'hFFFF0000, 32'h0000FFFF, 32'd0,        32'd0, 1'b0, 1);
        run("addwrap",4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b0, 1);
        run("subwrap",4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 1);
        run("multu",  4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33);
        run("multu2", 4'b1000, 32'h00010000, 32'h00010000, 32'd0,        32'd1, 1'b0, 33);
        run("divu",   4'b1001, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 33);
        run("divu0",  4'b1001, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b1, 1);
        run("divbig", 4'b1001, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'hF, 1'b0, 33);

        // backpressure: ADD 3+4 held for 5 cycles while inputs churn
        wait_idle("bp");
        bus.out_ready = 1'b0;
        bus.sel       = 4'b0010;
        bus.a         = 32'd3;
        bus.b         = 32'd4;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        check("bp.valid", bus.out_valid, 1);
        check("bp.lo0", bus.lo, 7);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            check("bp.hold_lo", bus.lo, 7);
            check("bp.hold_valid", bus.out_valid, 1);
            check("bp.hold_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.xfer_valid", bus.out_valid, 0);
        check("bp.xfer_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        check("bp.no_second", bus.out_valid, 0);

        // reset during MULTU 3x5
        bus.sel      = 4'b1000;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mrst.busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mrst.lo", bus.lo, 0);
        check("mrst.hi", bus.hi, 0);
        check("mrst.zf", bus.zf, 0);
        check("mrst.out_valid", bus.out_valid, 0);
        check("mrst.in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw = 1;
        end
        check("mrst.no_result", saw, 0);
        run("mul_after_rst", 4'b1000, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
